// File: rtl/output_mask_pkg.sv
// Shared definitions for the output masking producer and the receive-side unmask stream.
package output_mask_pkg;

  localparam int unsigned             OUT_MASK_W     = 32;
  localparam logic [OUT_MASK_W-1:0]   OUT_MASK_VALUE = 32'hC000_0003;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } occ_state_t;

endpackage

// File: rtl/output_unmask_skid2.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered from the next occupancy state.
module output_unmask_skid2
  import output_mask_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  occ_state_t       state, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] head, tail;
  logic             push, pop;
  logic             load_head_in, load_head_tail, load_tail;

  assign push = in_valid & in_ready_q;
  assign pop  = (state != ST_EMPTY) & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b0;
      head       <= '0;
      tail       <= '0;
    end else begin
      state      <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_head_in)
        head <= in_data;
      else if (load_head_tail)
        head <= tail;
      if (load_tail)
        tail <= in_data;
    end
  end

  always_comb begin
    state_d        = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_d      = ST_ONE;
          load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        // Simultaneous push and pop replaces the head and stays in ONE.
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_d   = ST_FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d        = ST_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = head;
  assign busy      = (state != ST_EMPTY);

endmodule

// File: rtl/output_unmask_stream.sv
// Strips the producer's XOR mask on the write side of a 2-entry skid buffer.
// Optional decoded-word counter enabled by OUTPUT_UNMASK_COUNT_EN.
module output_unmask_stream
  import output_mask_pkg::*;
#(
  parameter int unsigned     WIDTH = OUT_MASK_W,
  parameter logic [WIDTH-1:0] MASK = OUT_MASK_VALUE
`ifdef OUTPUT_UNMASK_COUNT_EN
  , parameter int unsigned   CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef OUTPUT_UNMASK_COUNT_EN
  , output logic [CNT_W-1:0] decoded_count
`endif
);

  logic [WIDTH-1:0] unmasked;

  assign unmasked = in_data ^ MASK;

  output_unmask_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (unmasked),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

`ifdef OUTPUT_UNMASK_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (out_valid && out_ready)
      cnt_q <= cnt_q + 1'b1;
  end

  assign decoded_count = cnt_q;
`endif

endmodule

// File: doc/output_unmask_stream.md
Name: output_unmask_stream

Overview:
- Receive-side counterpart of the combinational output-masking stage. That stage emits y = (a | b) ^ MASK.
- This block accepts the masked words over a valid/ready stream, strips the mask (XOR with the same constant), and buffers results in a 2-entry skid FIFO.
- Sits between the masked-output producer and any downstream consumer that needs the raw (a | b) value.
- Registered, fully back-pressurable.

Parameters:
- WIDTH, 32, data word width in bits.
- MASK, 32'hC000_0003, XOR constant; must equal the producer's constant. Bit-width is WIDTH.
- CNT_W, 16, width of the decoded-word counter (only used when the optional feature is enabled).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  masked word present on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  masked word y.
- out_valid  output  1  unmasked word present on out_data.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  recovered word = in_data ^ MASK.
- busy  output  1  at least one word held in the buffer.
- decoded_count  output  CNT_W  present only with OUTPUT_UNMASK_COUNT_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Buffer emptied, state EMPTY.
  - out_valid=0, out_data=0, in_ready=0 during the reset cycle, busy=0, decoded_count=0.
  - in_ready rises on the first cycle after rst deasserts.
  - Reset mid-transfer discards both entries; no word is emitted.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_data/out_valid are stable while out_valid=1 and out_ready=0.
- Datapath:
  - Unmasking is applied at write time: entry <= in_data ^ MASK.
  - Pure bitwise XOR; no width change, no carry.
  - Latency is 1 cycle: a word accepted at edge N is visible on out_data after edge N (i.e. in cycle N+1).
  - No combinational path from in_data to out_data.
- State machine (occupancy):
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input only -> FULL.
    - Output only -> EMPTY.
    - Input and output in the same cycle -> ONE, with the new word moving to the head.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer -> ONE, with the second entry promoted to the head.
    - Input is ignored while in FULL.
- Ordering:
  - Strict FIFO.
  - in_ready is registered: derived from state, never from out_ready combinationally.
- busy = (state != EMPTY).
- Simultaneous events in EMPTY: out_ready is irrelevant; no bypass path exists.
- Behaviour is deterministic when in_valid is asserted while in_ready=0: the word is not taken and the producer must hold it.

Optional Feature:
- Macro: OUTPUT_UNMASK_COUNT_EN.
- Defined:
  - Adds port decoded_count (CNT_W bits).
  - It increments by 1 on every output transfer and wraps modulo 2^CNT_W (all-ones + 1 -> 0).
  - Cleared by rst.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Decomposition:
- Shared package output_mask_pkg holds:
  - localparam OUT_MASK_W = 32;
  - localparam OUT_MASK_VALUE = 32'hC000_0003, also used by the producer;
  - the occupancy state enum {ST_EMPTY, ST_ONE, ST_FULL}.
- One natural sub-module: output_unmask_skid2. It is the generic 2-entry valid/ready buffer with no mask knowledge.
- The top instantiates it and applies the XOR on the write side, plus the optional counter.

Test Plan:
- Reset, then a single word: in_data=32'hC000_0003, out_ready=1 -> out_data=32'h0000_0000 one cycle later, out_valid high for 1 cycle, busy 1->0.
- Round trip with the producer: a=32'h0000_00F0, b=32'h0000_000F fed through the masker -> out_data=32'h0000_00FF.
- Back-pressure: out_ready=0, push 32'hFFFF_FFFF then 32'h0000_0000 -> in_ready=0 after 2 transfers.
  - Then release out_ready -> out_data 32'h3FFF_FFFC then 32'hC000_0003, in order.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with an incrementing input -> one output per cycle, state stays ONE, each out_data = input ^ MASK.
- Reset mid-operation: FIFO FULL, assert rst one cycle -> out_valid=0, busy=0, and the next accepted word is the first emitted.
- With OUTPUT_UNMASK_COUNT_EN and CNT_W=4: perform 17 output transfers -> decoded_count sequence 1..15, 0, 1.
